crc32_frame_packer: RTL and testbench

- Sits directly downstream of the table-based CRC32 encoder.
- Pairs each 512-bit data word with the 32-bit checksum the encoder produces one cycle later. The encoder's data passes through combinationally; its checksum is registered.
- Buffers the resulting {crc, data} frames in a small FIFO and serialises them onto a narrower valid/ready stream with a last-beat marker.
- Raises sticky error flags when the upstream pairing or flow-control contract is broken.

---
 rtl/crc32_pkg.sv | 21 ++
 rtl/crc32_frame_fifo.sv | 62 ++++++
 rtl/crc32_frame_packer.sv | 131 +++++++++++++
 tb/tb_crc32_frame_packer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// Shared constants, frame type, beat-count helper and output FSM states for the
// CRC32 frame packer.
package crc32_pkg;

  localparam int unsigned DATA_WIDTH  = 512;
  localparam int unsigned CRC_WIDTH   = 32;
  localparam int unsigned FRAME_WIDTH = DATA_WIDTH + CRC_WIDTH;

  typedef logic [FRAME_WIDTH-1:0] frame_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic int unsigned beats(input int unsigned frame_width,
                                        input int unsigned out_width);
    return (frame_width + out_width - 1) / out_width;
  endfunction

endpackage

// File: rtl/crc32_frame_fifo.sv
// Synchronous frame FIFO; a push while full is accepted only if a pop frees a
// slot in the same cycle.
module crc32_frame_fifo import crc32_pkg::*; #(
  parameter int unsigned WIDTH = FRAME_WIDTH,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o   = (count_q == CNT_W'(DEPTH));
    empty_o  = (count_q == '0);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/crc32_frame_packer.sv
// Pairs encoder data with its one-cycle-later checksum, queues {crc, data}
// frames and serialises them LSB-first onto an OUT_WIDTH valid/ready stream.
module crc32_frame_packer import crc32_pkg::*; #(
  parameter int unsigned DATA_WIDTH = crc32_pkg::DATA_WIDTH,
  parameter int unsigned CRC_WIDTH  = crc32_pkg::CRC_WIDTH,
  parameter int unsigned OUT_WIDTH  = 128,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  crc_valid_i,
  input  logic [CRC_WIDTH-1:0]  crc_i,
  output logic                  ready_o,
  output logic                  out_valid_o,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  overflow_o,
  output logic                  seq_err_o
);

  localparam int unsigned FRAME_W = DATA_WIDTH + CRC_WIDTH;
  localparam int unsigned BEATS   = beats(FRAME_W, OUT_WIDTH);
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  state_t                          state_q, state_d;
  logic [DATA_WIDTH-1:0]           stage_q, stage_d;
  logic                            stage_full_q, stage_full_d;
  logic [BEAT_W-1:0]               beat_q, beat_d;
  logic                            ready_q, ready_d;
  logic                            overflow_q, overflow_d;
  logic                            seq_err_q, seq_err_d;
  logic                            push, pop, handshake, last_beat;
  logic                            fifo_full, fifo_empty;
  logic [CNT_W-1:0]                fifo_count;
  logic [FRAME_W-1:0]              head;
  logic [BEATS-1:0][OUT_WIDTH-1:0] head_beats;

  crc32_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({crc_i, stage_q}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Zero-extending the head frame gives the padded final beat for free.
  assign head_beats = (BEATS * OUT_WIDTH)'(head);

  // Staging, sticky error flags and the advisory ready.
  always_comb begin
    stage_d      = stage_q;
    stage_full_d = stage_full_q;
    push         = crc_valid_i && stage_full_q;
    if (data_valid_i) begin
      stage_d      = data_i;
      stage_full_d = 1'b1;
    end else if (crc_valid_i) begin
      stage_full_d = 1'b0;
    end
    overflow_d = overflow_q || (push && fifo_full && !pop);
    seq_err_d  = seq_err_q || (crc_valid_i && !stage_full_q);
    ready_d    = (32'(fifo_count) + 32'(stage_full_q) + 32'(data_valid_i)) < DEPTH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Entering SEND on the push edge is what lets beat 0 appear one cycle after the crc.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty || push) state_d = SEND;
      SEND:    if (pop && (fifo_count == CNT_W'(1)) && !push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q == SEND);
    last_beat   = (beat_q == BEAT_W'(BEATS - 1));
    out_last_o  = out_valid_o && last_beat;
    out_data_o  = out_valid_o ? head_beats[beat_q] : '0;
    handshake   = out_valid_o && out_ready_i;
    pop         = handshake && last_beat;
    beat_d      = beat_q;
    if (pop) begin
      beat_d = '0;
    end else if (handshake) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      beat_q       <= '0;
      ready_q      <= 1'b0;
      overflow_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      stage_q      <= stage_d;
      stage_full_q <= stage_full_d;
      beat_q       <= beat_d;
      ready_q      <= ready_d;
      overflow_q   <= overflow_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign ready_o    = ready_q;
  assign overflow_o = overflow_q;
  assign seq_err_o  = seq_err_q;

endmodule

// File: tb/tb_crc32_frame_packer.sv
// Randomised self-checking bench for crc32_frame_packer against a queue-based
// frame model.
module tb_crc32_frame_packer;
  import crc32_pkg::*;

  localparam int unsigned DW    = 512;
  localparam int unsigned CW    = 32;
  localparam int unsigned OW    = 128;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW    = DW + CW;
  localparam int unsigned BEATS = 5;

  typedef logic [OW+4:0] obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dv = 1'b0, cv = 1'b0, ordy = 1'b0;
  logic [DW-1:0] d = '0;
  logic [CW-1:0] c = '0;
  logic          ready_o, out_valid_o, out_last_o, overflow_o, seq_err_o;
  logic [OW-1:0] out_data_o;

  int checks = 0;
  int errors = 0;

  // Model state: staged word plus a plain queue of whole frames.
  frame_t        mq[$];
  int            m_beat;
  bit            m_sf, m_ready, m_ovf, m_seq;
  logic [DW-1:0] m_stage;

  crc32_frame_packer #(
    .DATA_WIDTH (DW),
    .CRC_WIDTH  (CW),
    .OUT_WIDTH  (OW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_valid_i (dv),
    .data_i       (d),
    .crc_valid_i  (cv),
    .crc_i        (c),
    .ready_o      (ready_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .out_ready_i  (ordy),
    .overflow_o   (overflow_o),
    .seq_err_o    (seq_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [OW-1:0] beat_of(input frame_t f, input int k);
    logic [BEATS*OW-1:0] p;
    p = (BEATS * OW)'(f);
    return OW'(p >> (k * OW));
  endfunction

  function automatic obs_t exp_obs();
    bit            v;
    logic [OW-1:0] dat;
    v   = (mq.size() != 0);
    dat = '0;
    if (v) dat = beat_of(mq[0], m_beat);
    return {m_ready, v, v && (m_beat == BEATS - 1), m_ovf, m_seq, dat};
  endfunction

  function automatic obs_t got_obs();
    return {ready_o, out_valid_o, out_last_o, overflow_o, seq_err_o, out_data_o};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_beat  = 0;
    m_sf    = 0;
    m_stage = '0;
    m_ready = 0;
    m_ovf   = 0;
    m_seq   = 0;
  endtask

  task automatic model_step();
    bit v, hs, pp;
    v       = (mq.size() != 0);
    hs      = v && ordy;
    pp      = hs && (m_beat == BEATS - 1);
    m_ready = (mq.size() + int'(m_sf) + int'(dv)) < int'(DEPTH);
    if (pp) begin
      void'(mq.pop_front());
      m_beat = 0;
    end else if (hs) begin
      m_beat++;
    end
    if (cv) begin
      if (!m_sf) m_seq = 1;
      else if (mq.size() >= int'(DEPTH)) m_ovf = 1;
      else mq.push_back({c, m_stage});
    end
    if (dv) begin
      m_stage = d;
      m_sf    = 1;
    end else if (cv) begin
      m_sf = 0;
    end
  endtask

  task automatic drive(input logic v_dv, input logic [DW-1:0] v_d, input logic v_cv,
                       input logic [CW-1:0] v_c, input logic v_rdy);
    dv   = v_dv;
    d    = v_d;
    cv   = v_cv;
    c    = v_c;
    ordy = v_rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_obs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", got_obs());
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, '0, 0, '0, 1);
      checks++;
      if (got_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %h expected %h", i, got_obs(), exp_obs());
      end
      tick();
    end
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] dat;
    dat = {rand_data() >> 64, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 9; i++) begin
      if (i == 0) drive(1, dat, 0, '0, 1);
      else if (i == 1) drive(0, '0, 1, 32'hDEADBEEF, 1);
      else drive(0, '0, 0, '0, 1);
      checks++;
      if (got_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL single cyc %0d: got %h expected %h", i, got_obs(), exp_obs());
      end
      if (i == 2) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== dat[OW-1:0] || out_last_o !== 1'b0) begin
          errors++;
          $display("FAIL single_beat0: got v=%b l=%b %h expected v=1 l=0 %h",
                   out_valid_o, out_last_o, out_data_o, dat[OW-1:0]);
        end
      end
      if (i == 6) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== {96'h0, 32'hDEADBEEF} || out_last_o !== 1'b1) begin
          errors++;
          $display("FAIL single_beat4: got v=%b l=%b %h expected v=1 l=1 DEADBEEF",
                   out_valid_o, out_last_o, out_data_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int  beats_seen, lasts_seen, bad_last, gaps;
    bit  started;
    beats_seen = 0; lasts_seen = 0; bad_last = 0; gaps = 0; started = 0;
    for (int i = 0; i < 28; i++) begin
      drive(i < 4, rand_data(), (i >= 1 && i <= 4), 32'($urandom()), 1);
      checks++;
      if (got_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL b2b cyc %0d: got %h expected %h", i, got_obs(), exp_obs());
      end
      if (out_valid_o === 1'b1) begin
        started = 1;
        if (out_last_o === 1'b1) begin
          lasts_seen++;
          if (beats_seen % 5 != 4) bad_last++;
        end
        beats_seen++;
      end else if (started && beats_seen < 20) begin
        gaps++;
      end
      tick();
    end
    checks++;
    if (beats_seen != 20 || lasts_seen != 4 || bad_last != 0 || gaps != 0) begin
      errors++;
      $display("FAIL b2b_stream: beats=%0d lasts=%0d misplaced=%0d gaps=%0d expected 20 4 0 0",
               beats_seen, lasts_seen, bad_last, gaps);
    end
  endtask

  task automatic test_backpressure();
    int            held;
    logic [OW-1:0] hold_data;
    held = 0;
    hold_data = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) drive(1, rand_data(), 0, '0, 1);
      else if (i == 1) drive(0, '0, 1, 32'($urandom()), 1);
      else if (mq.size() != 0 && m_beat == 2 && held < 3) begin
        drive(0, '0, 0, '0, 0);
        if (held == 0) hold_data = out_data_o;
        held++;
      end else drive(0, '0, 0, '0, 1);
      checks++;
      if (got_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL bp cyc %0d: got %h expected %h", i, got_obs(), exp_obs());
      end
      if (ordy == 1'b0) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_last_o !== 1'b0 || out_data_o !== hold_data) begin
          errors++;
          $display("FAIL bp_hold cyc %0d: got v=%b l=%b %h expected v=1 l=0 %h",
                   i, out_valid_o, out_last_o, out_data_o, hold_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic prev_dv;
    prev_dv = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(ready_o && ($urandom_range(0, 1) == 1), rand_data(), prev_dv,
            32'($urandom()), $urandom_range(0, 3) != 0);
      prev_dv = dv;
      checks++;
      if (got_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h expected %h", i, got_obs(), exp_obs());
      end
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(0, '0, prev_dv, 32'($urandom()), 1);
      prev_dv = 1'b0;
      checks++;
      if (got_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL random_drain cyc %0d: got %h expected %h", i, got_obs(), exp_obs());
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    int frames_out;
    frames_out = 0;
    for (int i = 0; i < 9; i++) begin
      drive(i < 5, rand_data(), (i >= 1 && i <= 5), 32'($urandom()), 0);
      checks++;
      if (got_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL ovf_fill cyc %0d: got %h expected %h", i, got_obs(), exp_obs());
      end
      tick();
    end
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got %b expected 1", overflow_o);
    end
    for (int i = 0; i < 24; i++) begin
      drive(0, '0, 0, '0, 1);
      checks++;
      if (got_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL ovf_drain cyc %0d: got %h expected %h", i, got_obs(), exp_obs());
      end
      if (out_valid_o === 1'b1 && out_last_o === 1'b1) frames_out++;
      tick();
    end
    checks++;
    if (frames_out != 4 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained: frames=%0d ovf=%b expected 4 1", frames_out, overflow_o);
    end
  endtask

  task automatic test_seq_err();
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, i == 0, 32'($urandom()), 1);
      checks++;
      if (got_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL seq cyc %0d: got %h expected %h", i, got_obs(), exp_obs());
      end
      tick();
    end
    checks++;
    if (seq_err_o !== 1'b1 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL seq_flag: got seq=%b valid=%b expected 1 0", seq_err_o, out_valid_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] dat2;
    int            n;
    n = 0;
    drive(1, rand_data(), 0, '0, 1);
    tick();
    drive(0, '0, 1, 32'($urandom()), 1);
    tick();
    while (!(mq.size() != 0 && m_beat == 2) && n < 10) begin
      drive(0, '0, 0, '0, 1);
      tick();
      n++;
    end
    checks++;
    if (got_obs() !== exp_obs() || n >= 10) begin
      errors++;
      $display("FAIL rst_pre cyc %0d: got %h expected %h", n, got_obs(), exp_obs());
    end
    drive(0, '0, 0, '0, 1);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (got_obs() !== '0) begin
      errors++;
      $display("FAIL rst_async: got %h expected 0", got_obs());
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    dat2 = rand_data();
    for (int i = 0; i < 9; i++) begin
      if (i == 1) drive(1, dat2, 0, '0, 1);
      else if (i == 2) drive(0, '0, 1, 32'($urandom()), 1);
      else drive(0, '0, 0, '0, 1);
      checks++;
      if (got_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL rst_post cyc %0d: got %h expected %h", i, got_obs(), exp_obs());
      end
      if (i == 3) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== dat2[OW-1:0]) begin
          errors++;
          $display("FAIL rst_beat0: got v=%b %h expected v=1 %h", out_valid_o, out_data_o, dat2[OW-1:0]);
        end
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_overflow();
    test_seq_err();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
